// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its word array.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int WORD_W            = 32;
    localparam int DEFAULT_BASE_ADDR = 1024;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with a registered, read-enabled output.
// The storage itself is never reset; only the output register is.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: wait-state FSM, address translation and word array.
// Optional out-of-range checking is enabled by defining DMEM_RANGE_CHECK_EN.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 5,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int                IDX_W    = $clog2(DEPTH);
    localparam int                CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [31:0]       BASE     = 32'(BASE_ADDR);
    localparam logic [31:0]       SPAN     = 32'(4 * DEPTH);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              req;
    logic [31:0]       offset;
    logic [IDX_W-1:0]  idx;
    logic              oor;
    logic              complete;
    logic              we;
    logic              re;
    logic [31:0]       arr_rdata;

    assign req    = MEM_R_EN | MEM_W_EN;
    assign offset = addr - BASE;
    assign idx    = IDX_W'(offset >> 2);

`ifdef DMEM_RANGE_CHECK_EN
    // Below-base addresses wrap to huge offsets, so one unsigned compare covers both bounds.
    assign oor = (offset >= SPAN);
`else
    assign oor = 1'b0;
`endif

    // The edge that moves the FSM into DONE is the one that performs the access.
    assign complete = (state == IDLE && req && WAIT_CYCLES == 0) ||
                      (state == BUSY && cnt == CNT_LAST);
    assign we       = complete & MEM_W_EN & ~oor;
    assign re       = complete & MEM_R_EN & ~MEM_W_EN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cnt   <= '0;
                        state <= (WAIT_CYCLES == 0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:    ready = ~req;
            BUSY:    ready = 1'b0;
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    dmem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .re    (re),
        .idx   (idx),
        .wdata (wdata),
        .rdata (arr_rdata)
    );

`ifdef DMEM_RANGE_CHECK_EN
    logic rd_oor;
    logic err_q;

    // rd_oor remembers whether the last completed read was out of range so rdata shows 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_oor <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q <= complete & oor;
            if (re) begin
                rd_oor <= oor;
            end
        end
    end

    assign rdata = rd_oor ? '0 : arr_rdata;
    assign err   = err_q;
`else
    assign rdata = arr_rdata;
    assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder, run on a 5-wait-state and a 0-wait-state instance.
module tb_dmem_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] LO    = 32'd1024;
    localparam logic [31:0] HI    = 32'd1280;

`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    typedef struct {
        bit          is_read;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        r_en  [2];
    logic        w_en  [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        err   [2];

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] model [2][DEPTH];
    logic [31:0] last_rd [2];
    int          low_run [2];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_CYCLES(5)) dut_slow (
        .clk(clk), .rst(rst[0]), .MEM_R_EN(r_en[0]), .MEM_W_EN(w_en[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .err(err[0])
    );

    dmem_responder #(.WAIT_CYCLES(0)) dut_fast (
        .clk(clk), .rst(rst[1]), .MEM_R_EN(r_en[1]), .MEM_W_EN(w_en[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .err(err[1])
    );

    function automatic bit out_of_range(input logic [31:0] a);
        return RANGE_CHECK && (a < LO || a >= HI);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'(((a - LO) >> 2) % DEPTH);
    endfunction

    task automatic check_output(input string name, input int inst, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s inst=%0d got=%h expected=%h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    // Issue one access, predict its outcome from the reference model, then wait for DONE.
    task automatic apply_stimulus(input int i, input bit rd, input bit wr,
                                  input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        bit   oor  = out_of_range(a);
        int   w    = word_of(a);
        bit   seen = 1'b0;
        r_en[i]  = rd;
        w_en[i]  = wr;
        addr[i]  = a;
        wdata[i] = d;
        if (wr) begin
            if (!oor) model[i][w] = d;
            e.is_read = 1'b0;
        end else begin
            last_rd[i] = oor ? 32'h0 : model[i][w];
            e.is_read  = 1'b1;
        end
        e.rdata = last_rd[i];
        e.err   = oor;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (ready[i]) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("done_timeout", i, 32'(seen), 32'd1);
    endtask

    task automatic idle(input int i, input int n);
        r_en[i] = 1'b0;
        w_en[i] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mon_step(input int i);
        exp_t e;
        bit   have = 1'b0;
        int   lat  = (i == 0) ? 6 : 1;
        if (rst[i]) begin
            low_run[i] = 0;
            return;
        end
        if (!ready[i]) begin
            low_run[i]++;
        end else if (low_run[i] == 0) begin
            check_output("idle_err", i, 32'(err[i]), 32'd0);
        end else begin
            check_output("ready_low_cycles", i, 32'(low_run[i]), 32'(lat));
            low_run[i] = 0;
            if (i == 0 && q0.size() > 0) begin
                e = q0.pop_front();
                have = 1'b1;
            end else if (i == 1 && q1.size() > 0) begin
                e = q1.pop_front();
                have = 1'b1;
            end
            check_output("done_expected", i, 32'(have), 32'd1);
            if (have) begin
                check_output(e.is_read ? "read_rdata" : "write_rdata_hold", i, rdata[i], e.rdata);
                check_output("done_err", i, 32'(err[i]), 32'(e.err));
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) mon_step(i);
    end

    task automatic directed(input int i);
        apply_stimulus(i, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        idle(i, 1);
        apply_stimulus(i, 1'b1, 1'b0, 32'd1028, 32'h0);
        idle(i, 1);
        apply_stimulus(i, 1'b1, 1'b1, 32'd1032, 32'h12345678);
        apply_stimulus(i, 1'b1, 1'b0, 32'd1032, 32'h0);
        idle(i, 2);
        apply_stimulus(i, 1'b0, 1'b1, 32'd1280, 32'hA5A5A5A5);
        apply_stimulus(i, 1'b1, 1'b0, 32'd1024, 32'h0);
        apply_stimulus(i, 1'b1, 1'b0, 32'd1280, 32'h0);
        idle(i, 1);
        apply_stimulus(i, 1'b0, 1'b1, 32'd1031, 32'h00000001);
        apply_stimulus(i, 1'b1, 1'b0, 32'd1028, 32'h0);
        apply_stimulus(i, 1'b1, 1'b0, 32'd1024, 32'h0);
        apply_stimulus(i, 1'b1, 1'b0, 32'd1032, 32'h0);
        idle(i, 1);
    endtask

    task automatic random_phase(input int i, input int n);
        logic [31:0] a;
        int          kind;
        int          gap;
        for (int k = 0; k < n; k++) begin
            kind = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                a = ($urandom_range(0, 1) == 1) ? HI + 32'($urandom_range(0, 255))
                                                : LO - 32'd1 - 32'($urandom_range(0, 127));
            end else begin
                a = LO + 32'($urandom_range(0, 255));
            end
            apply_stimulus(i, kind != 2, kind >= 2, a, $urandom);
            gap = int'($urandom_range(0, 2));
            if (gap > 0) idle(i, gap);
        end
        idle(i, 1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i]     = 1'b1;
            r_en[i]    = 1'b1;
            w_en[i]    = 1'b0;
            addr[i]    = LO;
            wdata[i]   = 32'h0;
            last_rd[i] = 32'h0;
            low_run[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) check_output("reset_ready_req_high", i, 32'(ready[i]), 32'd0);
        for (int i = 0; i < 2; i++) r_en[i] = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_output("reset_ready", i, 32'(ready[i]), 32'd1);
            check_output("reset_rdata", i, rdata[i], 32'h0);
            check_output("reset_err", i, 32'(err[i]), 32'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) rst[i] = 1'b0;

        // Give every word a known value so later reads are fully predictable.
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < DEPTH; w++) apply_stimulus(i, 1'b0, 1'b1, LO + 32'(4 * w), $urandom);
            idle(i, 1);
        end

        for (int i = 0; i < 2; i++) directed(i);

        // Abort a write to word 0 mid-wait; the stored word must survive.
        w_en[0]  = 1'b1;
        addr[0]  = LO;
        wdata[0] = 32'hCAFEF00D;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst[0]  = 1'b1;
        w_en[0] = 1'b0;
        @(posedge clk);
        #1;
        check_output("abort_rdata_reset", 0, rdata[0], 32'h0);
        check_output("abort_ready", 0, 32'(ready[0]), 32'd1);
        rst[0]     = 1'b0;
        last_rd[0] = 32'h0;
        idle(0, 1);
        apply_stimulus(0, 1'b1, 1'b0, LO, 32'h0);
        idle(0, 1);

        for (int i = 0; i < 2; i++) random_phase(i, 120);

        idle(0, 3);
        check_output("queue_drain", 0, 32'(q0.size()), 32'd0);
        check_output("queue_drain", 1, 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
